// File: rtl/axis_sync_frame_fifo.sv
// axis_sync_frame_fifo: single-clock AXI-Stream FIFO with an optional
// store-and-forward frame mode (commit on tlast, drop bad or overflowing frames).
// Ports:
//   clk, reset                 clock and async active-high reset
//   s_axis_t{data,valid,ready,last,user}  write side; tuser marks a bad frame
//   m_axis_t{data,valid,ready,last}       read side, registered output
//   count, full, empty, almost_full, almost_empty  registered status
//   overflow, bad_frame, good_frame       one-cycle frame event pulses
module axis_sync_frame_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int FIFO_DEPTH        = 4096,
  parameter int ALMOST_FULL_DIFF  = 50,
  parameter int ALMOST_EMPTY_DIFF = 50,
  parameter int FRAME_MODE        = 1,
  parameter int DROP_BAD_FRAME    = 1,
  parameter int DROP_WHEN_FULL    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        bad_frame,
  output logic                        good_frame
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef enum logic {ST_WRITE, ST_DROP} state_t;

  localparam ptr_t DEPTH_P = ptr_t'(FIFO_DEPTH);

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

  state_t state, state_n;
  ptr_t   wr_cur, wr_cur_n;
  ptr_t   wr_com, wr_com_n;
  ptr_t   rd_ptr, rd_n;
  ptr_t   fe_ptr, fe_n;
  ptr_t   occ_n, cnt_n, free_n;
  logic   wr_acc, rd_acc, fetch, mem_we;
  logic   good_n, bad_n, ovf_n;
  logic   full_n;

  // rd_ptr advances on the output handshake, fe_ptr on the RAM fetch into
  // the output register, so the word held at the output still occupies
  // its slot and is still counted.
  always_comb begin
    wr_acc   = s_axis_tvalid && s_axis_tready;
    rd_acc   = m_axis_tvalid && m_axis_tready;
    fetch    = (wr_com != fe_ptr) && (!m_axis_tvalid || m_axis_tready);
    state_n  = state;
    wr_cur_n = wr_cur;
    wr_com_n = wr_com;
    mem_we   = 1'b0;
    good_n   = 1'b0;
    bad_n    = 1'b0;
    ovf_n    = 1'b0;
    rd_n     = rd_ptr + ptr_t'(rd_acc);
    fe_n     = fe_ptr + ptr_t'(fetch);
    if (FRAME_MODE == 0) begin
      if (wr_acc) begin
        mem_we   = 1'b1;
        wr_cur_n = wr_cur + 1'b1;
      end
      wr_com_n = wr_cur_n;
    end else begin
      unique case (state)
        ST_WRITE: begin
          if (wr_acc) begin
            if (s_axis_tlast && s_axis_tuser
                && DROP_BAD_FRAME != 0) begin
              wr_cur_n = wr_com;
              bad_n    = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wr_cur_n = wr_cur + 1'b1;
              if (s_axis_tlast) begin
                wr_com_n = wr_cur + 1'b1;
                good_n   = 1'b1;
              end
            end
          end else if (s_axis_tvalid && full
                       && wr_cur != wr_com
                       && DROP_WHEN_FULL != 0) begin
            // partial frame cannot fit: rewind and swallow the rest
            state_n  = ST_DROP;
            wr_cur_n = wr_com;
          end
        end
        ST_DROP: begin
          if (wr_acc && s_axis_tlast) begin
            state_n = ST_WRITE;
            ovf_n   = 1'b1;
          end
        end
        default: state_n = ST_WRITE;
      endcase
    end
    occ_n  = wr_cur_n - rd_n;
    cnt_n  = wr_com_n - rd_n;
    free_n = DEPTH_P - occ_n;
    full_n = (occ_n == DEPTH_P);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_WRITE;
      wr_cur        <= '0;
      wr_com        <= '0;
      rd_ptr        <= '0;
      fe_ptr        <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      s_axis_tready <= 1'b0;
      overflow      <= 1'b0;
      bad_frame     <= 1'b0;
      good_frame    <= 1'b0;
    end else begin
      state         <= state_n;
      wr_cur        <= wr_cur_n;
      wr_com        <= wr_com_n;
      rd_ptr        <= rd_n;
      fe_ptr        <= fe_n;
      count         <= cnt_n;
      full          <= full_n;
      empty         <= (cnt_n == '0);
      almost_full   <= int'(free_n) <= ALMOST_FULL_DIFF;
      almost_empty  <= int'(cnt_n) <= ALMOST_EMPTY_DIFF;
      s_axis_tready <= (state_n == ST_DROP) || !full_n;
      overflow      <= ovf_n;
      bad_frame     <= bad_n;
      good_frame    <= good_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_cur[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (fetch) begin
      {m_axis_tlast, m_axis_tdata} <= mem[fe_ptr[AW-1:0]];
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_sync_frame_fifo.sv
// tb_axis_sync_frame_fifo: three FIFO configurations against a queue model
// of committed/pending words, plus literal expectations per scenario.
module tb_axis_sync_frame_fifo;

  localparam int N = 3;
  localparam int DEP [N] = '{16, 128, 16};
  localparam int FM  [N] = '{0, 1, 1};
  localparam int AFD [N] = '{4, 50, 50};
  localparam int AED [N] = '{2, 50, 50};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] td [N];
  logic       tv [N], tl [N], tu [N], mr [N];
  logic       sr [N], mv [N], ml [N];
  logic [7:0] md [N];
  logic       full_o [N], empty_o [N];
  logic       af_o [N], ae_o [N];
  logic       ovf_o [N], bad_o [N], good_o [N];
  logic [4:0] cnt0, cnt2;
  logic [7:0] cnt1;
  int         cnt [N];

  always_comb begin
    cnt[0] = int'(cnt0);
    cnt[1] = int'(cnt1);
    cnt[2] = int'(cnt2);
  end

  axis_sync_frame_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16),
    .ALMOST_FULL_DIFF(4), .ALMOST_EMPTY_DIFF(2),
    .FRAME_MODE(0), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)
  ) u0 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(td[0]), .s_axis_tvalid(tv[0]),
    .s_axis_tready(sr[0]), .s_axis_tlast(tl[0]),
    .s_axis_tuser(tu[0]),
    .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tready(mr[0]), .m_axis_tlast(ml[0]),
    .count(cnt0), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]),
    .overflow(ovf_o[0]), .bad_frame(bad_o[0]),
    .good_frame(good_o[0])
  );

  axis_sync_frame_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(128),
    .ALMOST_FULL_DIFF(50), .ALMOST_EMPTY_DIFF(50),
    .FRAME_MODE(1), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)
  ) u1 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(td[1]), .s_axis_tvalid(tv[1]),
    .s_axis_tready(sr[1]), .s_axis_tlast(tl[1]),
    .s_axis_tuser(tu[1]),
    .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tready(mr[1]), .m_axis_tlast(ml[1]),
    .count(cnt1), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]),
    .overflow(ovf_o[1]), .bad_frame(bad_o[1]),
    .good_frame(good_o[1])
  );

  axis_sync_frame_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16),
    .ALMOST_FULL_DIFF(50), .ALMOST_EMPTY_DIFF(50),
    .FRAME_MODE(1), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)
  ) u2 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(td[2]), .s_axis_tvalid(tv[2]),
    .s_axis_tready(sr[2]), .s_axis_tlast(tl[2]),
    .s_axis_tuser(tu[2]),
    .m_axis_tdata(md[2]), .m_axis_tvalid(mv[2]),
    .m_axis_tready(mr[2]), .m_axis_tlast(ml[2]),
    .count(cnt2), .full(full_o[2]), .empty(empty_o[2]),
    .almost_full(af_o[2]), .almost_empty(ae_o[2]),
    .overflow(ovf_o[2]), .bad_frame(bad_o[2]),
    .good_frame(good_o[2])
  );

  int ntot = 0;
  int nbad = 0;
  int cyc = 0;

  task automatic check(string nm, int k, int act, int exp);
    ntot++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s dut%0d: got %0d want %0d",
               nm, k, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [8:0] cq [N][$];
  logic [8:0] pq [N][$];
  logic [8:0] e_out [N];
  bit e_ov [N], e_drop [N], e_ready [N], e_full [N];
  bit e_empty [N], e_af [N], e_ae [N];
  bit e_ovf [N], e_bad [N], e_good [N];
  int e_cnt [N];

  task automatic model_step(int k);
    bit acc;
    int occ;
    acc = tv[k] && e_ready[k];
    e_good[k] = 0;
    e_bad[k]  = 0;
    e_ovf[k]  = 0;
    if (e_ov[k] && mr[k]) e_ov[k] = 0;
    if (!e_ov[k] && cq[k].size() > 0) begin
      e_out[k] = cq[k].pop_front();
      e_ov[k]  = 1;
    end
    if (e_drop[k]) begin
      if (acc && tl[k]) begin
        e_drop[k] = 0;
        e_ovf[k]  = 1;
      end
    end else if (FM[k] == 0) begin
      if (acc) cq[k].push_back({tl[k], td[k]});
    end else if (acc) begin
      if (tl[k] && tu[k]) begin
        pq[k].delete();
        e_bad[k] = 1;
      end else begin
        pq[k].push_back({tl[k], td[k]});
        if (tl[k]) begin
          while (pq[k].size() > 0)
            cq[k].push_back(pq[k].pop_front());
          e_good[k] = 1;
        end
      end
    end else if (tv[k] && e_full[k] && pq[k].size() > 0) begin
      e_drop[k] = 1;
      pq[k].delete();
    end
    e_cnt[k]   = cq[k].size() + int'(e_ov[k]);
    occ        = e_cnt[k] + pq[k].size();
    e_full[k]  = (occ == DEP[k]);
    e_ready[k] = e_drop[k] || !e_full[k];
    e_empty[k] = (e_cnt[k] == 0);
    e_af[k]    = (DEP[k] - occ) <= AFD[k];
    e_ae[k]    = e_cnt[k] <= AED[k];
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        cq[k].delete();
        pq[k].delete();
        e_out[k] = '0;
        e_ov[k] = 0; e_drop[k] = 0; e_ready[k] = 0;
        e_full[k] = 0; e_empty[k] = 1;
        e_af[k] = 0; e_ae[k] = 1;
        e_ovf[k] = 0; e_bad[k] = 0; e_good[k] = 0;
        e_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) model_step(k);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- compare + monitor ----------------
  logic [8:0] got [N][$];
  int fv [N];
  int ngood [N], nbadf [N], novf [N];
  int tl_cyc [N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      check("s_tready", k, sr[k], e_ready[k]);
      check("m_tvalid", k, mv[k], e_ov[k]);
      if (mv[k]) begin
        check("m_tdata", k, md[k], e_out[k][7:0]);
        check("m_tlast", k, ml[k], e_out[k][8]);
      end
      check("count", k, cnt[k], e_cnt[k]);
      check("full", k, full_o[k], e_full[k]);
      check("empty", k, empty_o[k], e_empty[k]);
      check("almost_full", k, af_o[k], e_af[k]);
      check("almost_empty", k, ae_o[k], e_ae[k]);
      check("overflow", k, ovf_o[k], e_ovf[k]);
      check("bad_frame", k, bad_o[k], e_bad[k]);
      check("good_frame", k, good_o[k], e_good[k]);
      if (mv[k] && mr[k]) got[k].push_back({ml[k], md[k]});
      if (mv[k] && fv[k] < 0) fv[k] = cyc;
      if (good_o[k]) ngood[k]++;
      if (bad_o[k]) nbadf[k]++;
      if (ovf_o[k]) novf[k]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int k, logic [7:0] d, bit last, bit user);
    bit acc;
    int n;
    td[k] = d; tl[k] = last; tu[k] = user; tv[k] = 1'b1;
    acc = 0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = sr[k];
      if (acc && last) tl_cyc[k] = cyc;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 300) begin
        ntot++;
        nbad++;
        $display("FAIL send_timeout dut%0d: got stuck want accept", k);
        acc = 1;
      end
    end
    tv[k] = 1'b0; tl[k] = 1'b0; tu[k] = 1'b0;
  endtask

  task automatic wait_got(int k, int n, int lim);
    int c;
    c = 0;
    while (got[k].size() < n && c < lim) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_count", k, got[k].size(), n);
  endtask

  task automatic clr(int k);
    got[k].delete();
    fv[k] = -1;
    ngood[k] = 0; nbadf[k] = 0; novf[k] = 0;
  endtask

  function automatic int gw(int k, int i);
    if (i < got[k].size()) return int'(got[k][i]);
    return -1;
  endfunction

  // ---------------- directed scenarios ----------------
  logic [8:0] sent [$];
  bit stop;

  initial begin
    for (int k = 0; k < N; k++) begin
      td[k] = '0; tv[k] = 0; tl[k] = 0; tu[k] = 0; mr[k] = 0;
      tl_cyc[k] = 0;
      clr(k);
    end
    idle(3);
    for (int k = 0; k < N; k++) begin
      check("rst_tready", k, sr[k], 0);
      check("rst_tvalid", k, mv[k], 0);
      check("rst_count", k, cnt[k], 0);
      check("rst_empty", k, empty_o[k], 1);
      check("rst_aempty", k, ae_o[k], 1);
      check("rst_afull", k, af_o[k], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("tready_pre_edge", 0, sr[0], 0);
    @(posedge clk);
    #1;
    check("tready_post_edge", 0, sr[0], 1);

    // plain word FIFO: fill to full, then drain
    for (int i = 0; i < 16; i++) send(0, 8'(i), i == 15, 0);
    idle(3);
    check("t1_count16", 0, cnt[0], 16);
    check("t1_full", 0, full_o[0], 1);
    check("t1_tready0", 0, sr[0], 0);
    mr[0] = 1;
    wait_got(0, 16, 100);
    idle(2);
    check("t1_count0", 0, cnt[0], 0);
    check("t1_empty", 0, empty_o[0], 1);
    for (int i = 0; i < 16; i++)
      check("t1_data", 0, gw(0, i), {i == 15, 8'(i)});

    // 64-byte good frame, store-and-forward latency
    mr[1] = 1;
    clr(1);
    for (int i = 0; i < 64; i++) send(1, 8'(i), i == 63, 0);
    wait_got(1, 64, 200);
    check("t2_latency", 1, fv[1] - tl_cyc[1], 2);
    check("t2_good", 1, ngood[1], 1);
    for (int i = 0; i < 64; i++)
      check("t2_data", 1, gw(1, i), {i == 63, 8'(i)});

    // bad frame discarded, next frame intact
    clr(1);
    for (int i = 0; i < 20; i++) send(1, 8'(i + 32), i == 19, i == 19);
    idle(4);
    check("t3_bad", 1, nbadf[1], 1);
    check("t3_count", 1, cnt[1], 0);
    check("t3_nout", 1, got[1].size(), 0);
    for (int i = 0; i < 8; i++) send(1, 8'(8'hA0 + i), i == 7, 0);
    wait_got(1, 8, 50);
    check("t3_good", 1, ngood[1], 1);
    for (int i = 0; i < 8; i++)
      check("t3_data", 1, gw(1, i), {i == 7, 8'(8'hA0 + i)});

    // overflow drop on a 16-deep buffer
    clr(2);
    for (int i = 0; i < 10; i++) send(2, 8'(8'h10 + i), i == 9, 0);
    for (int i = 0; i < 12; i++) send(2, 8'(8'h40 + i), i == 11, 0);
    idle(3);
    check("t4_ovf", 2, novf[2], 1);
    check("t4_count", 2, cnt[2], 10);
    check("t4_good", 2, ngood[2], 1);
    mr[2] = 1;
    wait_got(2, 10, 60);
    for (int i = 0; i < 10; i++)
      check("t4_data", 2, gw(2, i), {i == 9, 8'(8'h10 + i)});
    idle(3);
    check("t4_empty", 2, empty_o[2], 1);

    // thresholds and pointer wrap with random valid/ready
    clr(0);
    sent.delete();
    stop = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          sent.push_back({i % 8 == 7, 8'(i * 3 + 5)});
          send(0, 8'(i * 3 + 5), i % 8 == 7, 0);
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          mr[0] = ($urandom_range(0, 3) == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    mr[0] = 1;
    wait_got(0, 40, 400);
    for (int i = 0; i < 40; i++)
      check("t5_data", 0, gw(0, i), int'(sent[i]));

    // reset in the middle of a frame
    clr(1);
    for (int i = 0; i < 5; i++) send(1, 8'(8'h70 + i), 0, 0);
    reset = 1'b1;
    #1;
    check("t6_tready", 1, sr[1], 0);
    check("t6_tvalid", 1, mv[1], 0);
    check("t6_count", 1, cnt[1], 0);
    check("t6_empty", 1, empty_o[1], 1);
    check("t6_aempty", 1, ae_o[1], 1);
    check("t6_good", 1, good_o[1], 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    clr(1);
    for (int i = 0; i < 4; i++) send(1, 8'(8'hC0 + i), i == 3, 0);
    wait_got(1, 4, 40);
    for (int i = 0; i < 4; i++)
      check("t6_data", 1, gw(1, i), {i == 3, 8'(8'hC0 + i)});
    check("t6_goodcnt", 1, ngood[1], 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/axis_sync_frame_fifo.md
Name: axis_sync_frame_fifo

Overview:
Single-clock AXI-Stream FIFO used between the RX/TX MAC and the UDP/IP layers when both sides share a clock domain. Parametrised in width and depth, with programmable almost-full/almost-empty thresholds and an optional store-and-forward frame mode. Frame mode commits whole frames only, rolls back frames flagged bad via tuser, and drops frames that overflow the buffer. Block-RAM storage with a registered output stage.

Parameters:
DATA_WIDTH, 8, tdata width in bits (any value >= 1).
FIFO_DEPTH, 4096, entries; must be a power of two >= 4. ADDR_WIDTH = log2(FIFO_DEPTH).
ALMOST_FULL_DIFF, 50, almost_full asserts when free entries <= this value.
ALMOST_EMPTY_DIFF, 50, almost_empty asserts when committed entries <= this value.
FRAME_MODE, 1, 1 = store-and-forward frame commit; 0 = plain word FIFO (tlast/tuser stored, not interpreted).
DROP_BAD_FRAME, 1, frame mode only: tlast with tuser=1 discards the frame.
DROP_WHEN_FULL, 1, frame mode only: a frame that hits full is discarded instead of back-pressuring.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  write data
s_axis_tvalid  in  1  write valid
s_axis_tready  out  1  write ready
s_axis_tlast  in  1  end of frame
s_axis_tuser  in  1  bad-frame flag, sampled with tlast
m_axis_tdata  out  DATA_WIDTH  read data
m_axis_tvalid  out  1  read valid
m_axis_tready  in  1  read ready
m_axis_tlast  out  1  end of frame
count  out  ADDR_WIDTH+1  committed entries (0..FIFO_DEPTH)
full  out  1  no free entry for the speculative write pointer
empty  out  1  no committed entry
almost_full  out  1  see ALMOST_FULL_DIFF
almost_empty  out  1  see ALMOST_EMPTY_DIFF
overflow  out  1  1-cycle pulse: frame dropped because of full
bad_frame  out  1  1-cycle pulse: frame dropped because of tuser
good_frame  out  1  1-cycle pulse: frame committed

Behaviour:
- Reset: pointers, count, m_axis_tvalid, m_axis_tlast, m_axis_tdata, pulses and s_axis_tready = 0. empty = 1, almost_empty = 1, full = 0, almost_full = 0. s_axis_tready rises on the first clk edge after reset deasserts. Reset mid-frame discards all contents, including the partial frame.
- Pointers are ADDR_WIDTH+1 bits and binary. They wrap modulo 2*FIFO_DEPTH.
  - wr_ptr_cur: speculative write pointer. wr_ptr_commit: committed write pointer. rd_ptr: read pointer.
  - full = (wr_ptr_cur - rd_ptr) == FIFO_DEPTH. empty = (wr_ptr_commit == rd_ptr). count = wr_ptr_commit - rd_ptr.
  - All status outputs are registered.
- Write handshake: a word transfers when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !full, or 1 while in DROP.
  - s_axis_tready has no combinational path from m_axis_tready. A read in cycle N frees space visible on s_axis_tready in cycle N+1.
- FRAME_MODE=0: wr_ptr_commit tracks wr_ptr_cur every cycle. Back-pressure on full.
- FRAME_MODE=1, write FSM has two states, WRITE and DROP:
  - WRITE, transfer without tlast: store the word, wr_ptr_cur+1.
  - WRITE, tlast with tuser=0: store the word, wr_ptr_commit <= wr_ptr_cur+1, good_frame pulse.
  - WRITE, tlast with tuser=1 and DROP_BAD_FRAME=1: wr_ptr_cur <= wr_ptr_commit, bad_frame pulse, word not stored.
  - WRITE, full while mid-frame and DROP_WHEN_FULL=1: go to DROP and set wr_ptr_cur <= wr_ptr_commit.
  - WRITE, full while mid-frame and DROP_WHEN_FULL=0: back-pressure. A frame larger than FIFO_DEPTH deadlocks; the integrator must prevent this.
  - DROP: accept and discard every word (tready=1). On tlast: overflow pulse, return to WRITE.
- Read path:
  - RAM read plus output register. One word is in flight from empty to m_axis_tvalid: a commit in cycle N gives m_axis_tvalid in cycle N+2.
  - m_axis_tdata/tlast are held stable while tvalid && !tready.
  - Back-to-back reads sustain 1 word/cycle.
- Simultaneous write and read at full: the read completes; the write is refused that cycle.
- Simultaneous commit and read: count reflects both in the same update.

Test Plan:
- Reset, then FRAME_MODE=0, DATA_WIDTH=8: write 0x00..0x0F, then read with tready=1 -> same 16 bytes in order, count goes 16 -> 0, empty=1 after the last read.
- FRAME_MODE=1: 64-byte frame with tuser=0; hold m_axis_tready=1 -> m_axis_tvalid stays 0 until 2 cycles after tlast, good_frame pulses once, 64 bytes out, m_axis_tlast on byte 63.
- FRAME_MODE=1: 20-byte frame with tuser=1 on tlast -> bad_frame pulses once, count stays 0, next good 8-byte frame is read out intact.
- FIFO_DEPTH=16, DROP_WHEN_FULL=1: 10-byte good frame, then a 12-byte frame with m_axis_tready=0 -> overflow pulses at the 12-byte tlast, count=10, the first frame is unaffected.
- Threshold wrap: FIFO_DEPTH=16, ALMOST_FULL_DIFF=4, ALMOST_EMPTY_DIFF=2, 40 words streamed with random valid/ready -> almost_full exactly when count>=12, almost_empty exactly when count<=2, data matches across pointer wrap.
- Assert reset mid-frame after 5 words -> all outputs at reset values immediately; after release, a new 4-byte frame passes cleanly.
